// File: rtl/router_port_map_pkg.sv
// rtl/router_port_map_pkg.sv - shared math and config-chain constants for router_port_map
// Purpose: configuration word width, words-per-entry computation, CLogB2 and
//          the FSM state type shared by the port-map table and its interface.
// Ports:   none (package).
package router_port_map_pkg;

  // Width of one word on the serial configuration chain.
  localparam int CFG_WORD_W = 16;

  // Number of bits needed to represent value (CLogB2(4) = 3, CLogB2(1) = 1).
  function automatic int clog_b2(input int value);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if ((value >> i) != 0) n = i + 1;
    end
    return n;
  endfunction

  // Configuration words needed to carry one entry of the given width.
  function automatic int words_per_entry(input int width);
    return (width + CFG_WORD_W - 1) / CFG_WORD_W;
  endfunction

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_PASS = 1'b1
  } state_t;

endpackage

// File: rtl/router_port_map_if.sv
// rtl/router_port_map_if.sv - config-chain and lookup bus of router_port_map
// Purpose: groups the configuration chain (in/out), reload/config_done and the
//          NLOOKUP lookup channels into one bundle.
// Ports:   master drives config words, reload and lookup requests;
//          slave (the table) drives forwarded words, config_done and results.
interface router_port_map_if
  import router_port_map_pkg::*;
#(
  parameter int NPORTS  = 5,
  parameter int WIDTH   = 8,
  parameter int NLOOKUP = 2
) ();

  localparam int LOG_NPORTS = clog_b2(NPORTS - 1);

  logic [CFG_WORD_W-1:0]         ram_config_in;
  logic                          ram_config_in_valid;
  logic [CFG_WORD_W-1:0]         ram_config_out;
  logic                          ram_config_out_valid;
  logic                          reload;
  logic                          config_done;
  logic [NLOOKUP*LOG_NPORTS-1:0] lookup_id;
  logic [NLOOKUP-1:0]            lookup_req;
  logic [NLOOKUP*WIDTH-1:0]      lookup_haddr;
  logic [NLOOKUP-1:0]            lookup_ack;
  logic [NLOOKUP-1:0]            lookup_err;

  modport master (
    output ram_config_in, ram_config_in_valid, reload, lookup_id, lookup_req,
    input  ram_config_out, ram_config_out_valid, config_done,
           lookup_haddr, lookup_ack, lookup_err
  );

  modport slave (
    input  ram_config_in, ram_config_in_valid, reload, lookup_id, lookup_req,
    output ram_config_out, ram_config_out_valid, config_done,
           lookup_haddr, lookup_ack, lookup_err
  );

endinterface

// File: rtl/router_port_map_config_deserializer.sv
// rtl/router_port_map_config_deserializer.sv - packs 16-bit config words into one table entry
// Purpose: collects WPE words (least-significant first) and presents the packed
//          entry together with a one-cycle entry_valid strobe on the last word.
// Ports:   clock, reset (async active-low), clear (sync restart), word/word_valid in,
//          entry/entry_valid out (combinational from the current word).
module router_port_map_config_deserializer
  import router_port_map_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [CFG_WORD_W-1:0] word,
  input  logic                  word_valid,
  output logic [WIDTH-1:0]      entry,
  output logic                  entry_valid
);

  localparam int   WPE       = words_per_entry(WIDTH);
  localparam logic LAST_WORD = 1'(WPE - 1);

  logic                  word_cnt;
  logic [CFG_WORD_W-1:0] low_word;
  logic [2*CFG_WORD_W-1:0] assembled;
  logic                  unused_bits;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_cnt <= 1'b0;
      low_word <= '0;
    end else if (clear) begin
      word_cnt <= 1'b0;
    end else if (word_valid) begin
      low_word <= word;
      word_cnt <= (word_cnt == LAST_WORD) ? 1'b0 : word_cnt + 1'b1;
    end
  end

  // The last word is used straight from the input so the entry is written
  // in the same cycle it completes; bits above WIDTH are dropped here.
  always_comb begin
    assembled = '0;
    if (WPE == 1) assembled = {{CFG_WORD_W{1'b0}}, word};
    else          assembled = {word, low_word};
  end

  assign entry       = assembled[WIDTH-1:0];
  assign entry_valid = word_valid && (word_cnt == LAST_WORD);
  assign unused_bits = ^assembled;

endmodule

// File: rtl/router_port_map.sv
// rtl/router_port_map.sv - router port-ID to node-address lookup table on the config chain
// Purpose: loads NPORTS entries from the serial config chain (LOAD), then forwards
//          further config words (PASS) and serves NLOOKUP registered lookups.
// Ports:   clock, reset (async active-low), bus (router_port_map_if.slave):
//          config in/out chain, reload, config_done, lookup_id/req -> haddr/ack/err.
module router_port_map
  import router_port_map_pkg::*;
#(
  parameter int NPORTS  = 5,
  parameter int WIDTH   = 8,
  parameter int NLOOKUP = 2
) (
  input  logic              clock,
  input  logic              reset,
  router_port_map_if.slave  bus
);

  localparam int LOG_NPORTS = clog_b2(NPORTS - 1);
  localparam logic [LOG_NPORTS-1:0] LAST_ENTRY = LOG_NPORTS'(NPORTS - 1);
  localparam logic [LOG_NPORTS:0]   NPORTS_W   = (LOG_NPORTS + 1)'(NPORTS);

  state_t                state, state_next;
  logic [LOG_NPORTS-1:0] entry_cnt, entry_cnt_next;
  logic                  word_valid;
  logic [WIDTH-1:0]      entry;
  logic                  entry_valid;
  logic                  wr_en;

  logic [WIDTH-1:0]      mem [NPORTS];

  // A word arriving alongside reload in LOAD is discarded.
  assign word_valid = (state == ST_LOAD) && bus.ram_config_in_valid && !bus.reload;

  router_port_map_config_deserializer #(
    .WIDTH (WIDTH)
  ) u_deser (
    .clock       (clock),
    .reset       (reset),
    .clear       (bus.reload),
    .word        (bus.ram_config_in),
    .word_valid  (word_valid),
    .entry       (entry),
    .entry_valid (entry_valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_LOAD;
      entry_cnt <= '0;
    end else begin
      state     <= state_next;
      entry_cnt <= entry_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    entry_cnt_next = entry_cnt;
    wr_en          = 1'b0;
    case (state)
      ST_LOAD: begin
        if (bus.reload) begin
          entry_cnt_next = '0;
        end else if (entry_valid) begin
          wr_en = 1'b1;
          if (entry_cnt == LAST_ENTRY) begin
            state_next     = ST_PASS;
            entry_cnt_next = '0;
          end else begin
            entry_cnt_next = entry_cnt + 1'b1;
          end
        end
      end
      ST_PASS: begin
        if (bus.reload) begin
          state_next     = ST_LOAD;
          entry_cnt_next = '0;
        end
      end
      default: state_next = ST_LOAD;
    endcase
  end

  assign bus.config_done = (state == ST_PASS);

  // Table storage is deliberately not reset; entries survive reload until rewritten.
  always_ff @(posedge clock) begin
    if (wr_en) mem[entry_cnt] <= entry;
  end

  // Forwarding: registered copy of every word seen in PASS, including one
  // arriving in the same cycle as reload.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.ram_config_out       <= '0;
      bus.ram_config_out_valid <= 1'b0;
    end else begin
      bus.ram_config_out_valid <= (state == ST_PASS) && bus.ram_config_in_valid;
      if ((state == ST_PASS) && bus.ram_config_in_valid)
        bus.ram_config_out <= bus.ram_config_in;
    end
  end

  // Lookups: every channel reads the flop array independently.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.lookup_haddr <= '0;
      bus.lookup_ack   <= '0;
      bus.lookup_err   <= '0;
    end else begin
      for (int k = 0; k < NLOOKUP; k++) begin
        logic [LOG_NPORTS-1:0] id;
        logic                  hit;
        id  = bus.lookup_id[k*LOG_NPORTS +: LOG_NPORTS];
        hit = bus.config_done && ({1'b0, id} < NPORTS_W);
        bus.lookup_ack[k] <= bus.lookup_req[k];
        if (bus.lookup_req[k]) begin
          bus.lookup_haddr[k*WIDTH +: WIDTH] <= hit ? mem[id] : '0;
          bus.lookup_err[k]                  <= !hit;
        end else begin
          bus.lookup_haddr[k*WIDTH +: WIDTH] <= '0;
          bus.lookup_err[k]                  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_port_map.sv
// tb/tb_router_port_map.sv - directed self-checking bench for router_port_map
// Purpose: two instances (5 x 8-bit, 2 channels; 3 x 24-bit, 1 channel) driven
//          through load, lookup, pass-through, reload and reset-mid-load steps.
// Ports:   none (top-level bench).
module tb_router_port_map;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  router_port_map_if #(.NPORTS(5), .WIDTH(8),  .NLOOKUP(2)) bus  ();
  router_port_map_if #(.NPORTS(3), .WIDTH(24), .NLOOKUP(1)) wbus ();

  router_port_map #(.NPORTS(5), .WIDTH(8), .NLOOKUP(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  router_port_map #(.NPORTS(3), .WIDTH(24), .NLOOKUP(1)) dut_w (
    .clock (clock),
    .reset (reset),
    .bus   (wbus)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed_a(input logic [15:0] w);
    bus.ram_config_in       = w;
    bus.ram_config_in_valid = 1'b1;
    tick;
    bus.ram_config_in_valid = 1'b0;
  endtask

  task automatic feed_w(input logic [15:0] w);
    wbus.ram_config_in       = w;
    wbus.ram_config_in_valid = 1'b1;
    tick;
    wbus.ram_config_in_valid = 1'b0;
  endtask

  initial begin
    bus.ram_config_in        = '0;
    bus.ram_config_in_valid  = 1'b0;
    bus.reload               = 1'b0;
    bus.lookup_id            = '0;
    bus.lookup_req           = '0;
    wbus.ram_config_in       = '0;
    wbus.ram_config_in_valid = 1'b0;
    wbus.reload              = 1'b0;
    wbus.lookup_id           = '0;
    wbus.lookup_req          = '0;

    // Reset state
    tick;
    tick;
    check("rst_done",      bus.config_done, 1'b0);
    check("rst_out_valid", bus.ram_config_out_valid, 1'b0);
    check("rst_out",       bus.ram_config_out, 16'h0);
    check("rst_ack",       bus.lookup_ack, 2'b00);
    check("rst_err",       bus.lookup_err, 2'b00);
    check("rst_haddr",     bus.lookup_haddr, 16'h0);
    check("rst_w_done",    wbus.config_done, 1'b0);
    reset = 1'b1;
    tick;

    // Lookup before configuration
    bus.lookup_id  = {3'd2, 3'd0};
    bus.lookup_req = 2'b11;
    tick;
    bus.lookup_req = 2'b00;
    check("early_ack",   bus.lookup_ack, 2'b11);
    check("early_err",   bus.lookup_err, 2'b11);
    check("early_haddr", bus.lookup_haddr, 16'h0);

    // Basic load 0x11..0x55
    feed_a(16'h0011);
    feed_a(16'h0022);
    feed_a(16'h0033);
    feed_a(16'h0044);
    check("load4_done",      bus.config_done, 1'b0);
    check("load4_out_valid", bus.ram_config_out_valid, 1'b0);
    feed_a(16'h0055);
    check("load5_done",      bus.config_done, 1'b1);
    check("load5_out_valid", bus.ram_config_out_valid, 1'b0);

    // Two channels, same cycle
    bus.lookup_id  = {3'd0, 3'd3};
    bus.lookup_req = 2'b11;
    tick;
    check("lk30_haddr", bus.lookup_haddr, 16'h1144);
    check("lk30_err",   bus.lookup_err, 2'b00);
    check("lk30_ack",   bus.lookup_ack, 2'b11);

    // ch0 out of range (6), ch1 at last entry (4)
    bus.lookup_id = {3'd4, 3'd6};
    tick;
    bus.lookup_req = 2'b00;
    check("lk64_haddr", bus.lookup_haddr, 16'h5500);
    check("lk64_err",   bus.lookup_err, 2'b01);
    tick;
    check("idle_ack", bus.lookup_ack, 2'b00);

    // Pass-through, back-to-back
    bus.ram_config_in       = 16'hA5A5;
    bus.ram_config_in_valid = 1'b1;
    tick;
    check("fwd1_out",   bus.ram_config_out, 16'hA5A5);
    check("fwd1_valid", bus.ram_config_out_valid, 1'b1);
    bus.ram_config_in = 16'h5A5A;
    tick;
    bus.ram_config_in_valid = 1'b0;
    check("fwd2_out",   bus.ram_config_out, 16'h5A5A);
    check("fwd2_valid", bus.ram_config_out_valid, 1'b1);
    tick;
    check("fwd_idle_valid", bus.ram_config_out_valid, 1'b0);

    // Reload in PASS with a word in the same cycle
    bus.reload = 1'b1;
    feed_a(16'hC3C3);
    bus.reload = 1'b0;
    check("rl_fwd_out",   bus.ram_config_out, 16'hC3C3);
    check("rl_fwd_valid", bus.ram_config_out_valid, 1'b1);
    check("rl_done",      bus.config_done, 1'b0);

    // Lookup while reloading returns err even for a previously loaded entry
    bus.lookup_id  = {3'd0, 3'd4};
    bus.lookup_req = 2'b11;
    tick;
    bus.lookup_req = 2'b00;
    check("rl_lk_err",   bus.lookup_err, 2'b11);
    check("rl_lk_haddr", bus.lookup_haddr, 16'h0);
    check("rl_lk_ack",   bus.lookup_ack, 2'b11);

    // Partial load, then reload in LOAD with a discarded word
    feed_a(16'h7701);
    feed_a(16'h7702);
    check("partial_out_valid", bus.ram_config_out_valid, 1'b0);
    bus.reload = 1'b1;
    feed_a(16'h00EE);
    bus.reload = 1'b0;
    check("rl_load_done", bus.config_done, 1'b0);

    // New values; upper byte of each word lies above WIDTH and is dropped
    for (int i = 1; i <= 5; i++) begin
      feed_a(16'h7700 + 16'(i));
    end
    check("reload_done", bus.config_done, 1'b1);
    bus.lookup_id  = {3'd0, 3'd4};
    bus.lookup_req = 2'b11;
    tick;
    bus.lookup_req = 2'b00;
    check("reload_haddr", bus.lookup_haddr, 16'h0105);
    check("reload_err",   bus.lookup_err, 2'b00);

    // Reset mid-load
    bus.reload = 1'b1;
    tick;
    bus.reload = 1'b0;
    feed_a(16'h0021);
    feed_a(16'h0022);
    bus.lookup_id  = '0;
    bus.lookup_req = 2'b11;
    feed_a(16'h0023);
    bus.lookup_req = 2'b00;
    check("pre_rst_ack", bus.lookup_ack, 2'b11);
    check("pre_rst_err", bus.lookup_err, 2'b11);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_done",      bus.config_done, 1'b0);
    check("mid_rst_out",       bus.ram_config_out, 16'h0);
    check("mid_rst_out_valid", bus.ram_config_out_valid, 1'b0);
    check("mid_rst_ack",       bus.lookup_ack, 2'b00);
    check("mid_rst_err",       bus.lookup_err, 2'b00);
    check("mid_rst_haddr",     bus.lookup_haddr, 16'h0);
    tick;
    reset = 1'b1;
    tick;
    for (int i = 1; i <= 5; i++) begin
      feed_a(16'h0030 + 16'(i));
    end
    check("post_rst_done", bus.config_done, 1'b1);
    bus.lookup_id  = {3'd3, 3'd0};
    bus.lookup_req = 2'b11;
    tick;
    bus.lookup_req = 2'b00;
    check("post_rst_haddr", bus.lookup_haddr, 16'h3431);
    check("post_rst_err",   bus.lookup_err, 2'b00);

    // Wide entries: two words per entry
    feed_w(16'h1111);
    feed_w(16'h0022);
    feed_w(16'h3333);
    feed_w(16'hFF44);
    feed_w(16'hBEEF);
    check("w_done5", wbus.config_done, 1'b0);
    feed_w(16'h00AD);
    check("w_done6", wbus.config_done, 1'b1);
    wbus.lookup_id  = 2'd2;
    wbus.lookup_req = 1'b1;
    tick;
    check("w_lk2_haddr", wbus.lookup_haddr, 24'hADBEEF);
    check("w_lk2_err",   wbus.lookup_err, 1'b0);
    wbus.lookup_id = 2'd1;
    tick;
    check("w_lk1_haddr", wbus.lookup_haddr, 24'h443333);
    wbus.lookup_id = 2'd3;
    tick;
    wbus.lookup_req = 1'b0;
    check("w_lk3_haddr", wbus.lookup_haddr, 24'h0);
    check("w_lk3_err",   wbus.lookup_err, 1'b1);
    check("w_lk3_ack",   wbus.lookup_ack, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_port_map.md
# router_port_map

Parametrised router-port-to-node-address lookup table with a serial 16-bit configuration chain, multiple independent lookup channels and runtime reload. It sits beside each router and converts local output-port IDs into physical node addresses (haddr) for the routing and injection logic. It supports entries wider than one configuration word, registered multi-channel lookups with miss/range reporting, and re-entry into load mode without a global reset. Configuration words not consumed by this table are forwarded to the next block on the chain.

## Interface
Parameters:
- NPORTS, 5: number of table entries (port IDs 0..NPORTS-1); must be at least 2.
- WIDTH, 8: haddr width, 1..32.
- NLOOKUP, 2: number of independent lookup channels, 1..4.
- LOG_NPORTS (localparam): CLogB2(NPORTS-1).
- WPE (localparam): words per entry, (WIDTH+15)/16, so 1 or 2.

Ports:
- clock  in  1  the only clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low.
- ram_config_in  in  16  configuration word.
- ram_config_in_valid  in  1  ram_config_in is valid this cycle.
- ram_config_out  out  16  registered forwarded word.
- ram_config_out_valid  out  1  forwarded word is valid.
- reload  in  1  single-cycle pulse; restarts loading.
- config_done  out  1  all NPORTS entries are loaded.
- lookup_id  in  NLOOKUP*LOG_NPORTS  port ID for each channel; channel k uses bits [k*LOG_NPORTS +: LOG_NPORTS].
- lookup_req  in  NLOOKUP  per-channel lookup request.
- lookup_haddr  out  NLOOKUP*WIDTH  per-channel result.
- lookup_ack  out  NLOOKUP  per-channel result valid.
- lookup_err  out  NLOOKUP  per-channel error: ID >= NPORTS, or table not configured.

## Operation
- The FSM has two states, LOAD and PASS. Reset enters LOAD.
- Counters:
  - word_cnt runs 0..WPE-1.
  - entry_cnt runs 0..NPORTS-1.
- In LOAD, each valid word is consumed and nothing is forwarded.
  - Words arrive least-significant first and are packed by the deserializer.
  - On the last word of an entry (word_cnt == WPE-1), the entry is written at entry_cnt, word_cnt clears and entry_cnt increments.
  - Writing entry NPORTS-1 moves the FSM to PASS.
  - Bits above WIDTH in the final word are ignored.
- In PASS, every valid word is forwarded: ram_config_out and ram_config_out_valid are registered copies of the inputs. config_done = (state == PASS).
- reload in PASS:
  - The FSM returns to LOAD next cycle and clears word_cnt and entry_cnt.
  - Table contents are kept until each entry is overwritten.
  - A word valid in the same cycle as reload is still forwarded.
- reload in LOAD clears both counters; a word valid in the same cycle is discarded.
- Lookup on channel k, registered with one-cycle latency:
  - lookup_ack[k] follows lookup_req[k] on the next cycle.
  - When config_done is 1 and the ID is below NPORTS: haddr = table[ID], err = 0.
  - Otherwise: haddr = 0, err = 1.
  - Channels are fully independent. Any number may read the same entry in the same cycle.
- Lookup vs. write in the same cycle: a write only happens in LOAD, and lookups in LOAD always return err, so there is no read-during-write hazard.

## Timing
- Reset values:
  - ram_config_out = 0, ram_config_out_valid = 0.
  - config_done = 0.
  - lookup_haddr = 0, lookup_ack = 0, lookup_err = 0.
  - The table storage is not reset.
- Configuration latency: config_done rises on the cycle after the (NPORTS*WPE)-th accepted word.
- Forwarding latency is 1 cycle. The first forwarded word is the first valid word that arrives while config_done = 1.
- Lookup latency is 1 cycle. There is no backpressure.
- A reset asserted mid-load or mid-pass clears the FSM, counters and outputs immediately. The next load starts at entry 0, word 0.
- Counter wrap: entry_cnt never exceeds NPORTS-1, because the FSM leaves LOAD on the final write.

## Structure
- CLogB2 stays in the shared math include.
- The configuration word width (16) and the WPE computation belong in the shared const include, so other config-chain blocks use the same values.
- Storage is a flop array of NPORTS x WIDTH, so NLOOKUP read ports come free. DistroRAM is not used, because it has only one read port.
- One sub-module, config_deserializer:
  - Packs WPE 16-bit words into one WIDTH-bit entry.
  - Outputs an entry and an entry_valid strobe.
  - Clears on reset and on reload.

## Test plan
- Basic load and lookup (NPORTS=5, WIDTH=8):
  - Feed words 0x11, 0x22, 0x33, 0x44, 0x55; config_done rises one cycle after 0x55.
  - Request ch0 = 3 and ch1 = 0 in the same cycle; next cycle haddr = 0x44 and 0x11, err = 00.
- Wide entries (WIDTH=24, WPE=2):
  - Entry 2 is loaded as 0xBEEF then 0x00AD.
  - A lookup of ID 2 returns 0xADBEEF.
- Pass-through:
  - After load, words 0xA5A5 and 0x5A5A arrive back-to-back.
  - ram_config_out shows them on the following two cycles with valid high; nothing is forwarded during LOAD.
- Errors:
  - A lookup of ID 6 after load gives haddr = 0, err = 1.
  - Any lookup before config_done gives err = 1, ack = 1.
- Reload:
  - Reload in PASS with a word valid in the same cycle: that word is forwarded.
  - Load new values 0x01..0x05; lookup ID 4 returns 0x05.
- Reset mid-load:
  - Assert reset after 3 of 5 words; config_done and all outputs read 0 immediately.
  - Reload all 5 words; a lookup of ID 0 returns the new first word.
